layer_priority_mux: RTL
=======================

Name: layer_priority_mux

Overview:
- Parametrised successor to the fixed-priority VGA object mux. It merges NUM_LAYERS sprite/background layers and a fallback background into one pixel stream.
- Layer priority is set at runtime through a rank table. Layers can be individually enabled, and pixels matching the transparent colour key are treated as not drawing.
- Each frame, it latches which layers overlapped another drawing layer, so game logic gets a collision vector.
- Sits between the object drawers (player, bomb, blast, enemy, borders, columns) and the VGA output register.

Parameters:
- NUM_LAYERS, 8, number of drawable layer inputs (2..16).
- RGB_W, 8, pixel colour width.
- TRANSP_EN, 1, when 1, a layer pixel equal to TRANSPARENT counts as not drawing.
- TRANSPARENT, 8'hFF, colour key, RGB_W bits.
- RANK_W, $clog2(NUM_LAYERS), rank field width (derived; do not override).

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  synchronous active-low reset.
- layerDR  in  NUM_LAYERS  per-layer draw request; bit i belongs to layer i.
- layerRGB  in  NUM_LAYERS*RGB_W  layer colours; layer i occupies bits [i*RGB_W +: RGB_W].
- layerEnable  in  NUM_LAYERS  per-layer enable mask.
- backgroundRGB  in  RGB_W  colour used when no layer wins.
- startOfFrame  in  1  one-cycle pulse aligned with the first pixel of a frame.
- rankWrEn  in  1  rank table write strobe.
- rankWrIdx  in  RANK_W  layer index to write.
- rankWrVal  in  RANK_W  new rank; 0 is highest priority.
- RGBOut  out  RGB_W  merged pixel.
- hitValid  out  1  some layer won this pixel.
- hitLayer  out  RANK_W  index of the winning layer; 0 when hitValid=0.
- collisionOut  out  NUM_LAYERS  layers that collided during the previous frame.
- collisionValid  out  1  one-cycle pulse when collisionOut updates.

Behaviour:
- Reset (resetN=0 at clk edge) clears: RGBOut=0, hitValid=0, hitLayer=0, collisionOut=0, collisionValid=0, both pipeline stages, and the collision accumulator. The rank table resets to identity (rank[i]=i), which reproduces a fixed index-order priority.
- Reset is synchronous: a reset asserted mid-frame takes effect on the next edge. The first frame after reset produces an all-zero collisionOut.
- Stage 1 (registered):
  - draw[i] = layerDR[i] & layerEnable[i] & !(TRANSP_EN & layerRGB[i]==TRANSPARENT).
  - draw, the RGBs, backgroundRGB and startOfFrame are all registered.
- Stage 2 (registered):
  - Winner is the drawing layer with the lowest rank. Ties on equal rank go to the lower index.
  - RGBOut = winner RGB; hitValid=1; hitLayer = winner index.
  - If no layer draws: RGBOut = background, hitValid=0, hitLayer=0.
- Latency is exactly 2 clocks from input pixel to RGBOut/hitLayer, with throughput one pixel per clock. There is no stall or handshake.
- Rank writes:
  - A write updates rank[rankWrIdx] at the edge where rankWrEn=1.
  - Stage 2 selection uses the new value from the following cycle onward.
  - rankWrIdx >= NUM_LAYERS is ignored.
  - Duplicate ranks are legal and resolved by the tie rule.
- Collision accumulator (acc), using stage-1 registered draw:
  - A pixel where popcount(draw) >= 2 ORs draw into acc. Pixels with fewer than two drawing layers leave acc unchanged.
  - When registered startOfFrame=1: collisionOut <= acc (excluding the current pixel), collisionValid <= 1, and acc <= the current pixel's contribution (draw if popcount>=2, else 0).
  - Otherwise collisionValid <= 0, and collisionOut holds its value.
  - Because collisionValid is driven from the stage-1 startOfFrame, it pulses 2 cycles after the input startOfFrame.
- Disabled or transparent layers never win and never count toward collisions.
- NUM_LAYERS=1: a collision is impossible, so collisionOut stays 0.

Decomposition:
- Shared package vga_layers_pkg holds:
  - layer index constants LAYER_COLUMNS=0, LAYER_BORDERS=1, LAYER_BLAST=2, LAYER_PLAYER=3, LAYER_ENEMY=4, LAYER_BOMB=5;
  - default NUM_LAYERS;
  - TRANSPARENT_COLOR;
  - a rank_t typedef.
- One combinational sub-module, rank_select. Its inputs are the draw vector and the rank table; its outputs are winner index and found. The selection logic is a linear scan, with a strict less-than comparison on rank so the tie rule holds.
- This block holds the registers, the rank table and the collision accumulator.

Test Plan:
- Identity ranks; layers 3 and 5 draw with RGB 8'h1C and 8'hE0 -> after 2 clocks RGBOut=8'h1C, hitLayer=3, hitValid=1.
- Write rank[5]=0 and rank[3]=2, then repeat the same pixel -> RGBOut=8'hE0, hitLayer=5. Write rank[3]=0 as well so both hold rank 0 -> layer 3 wins.
- Layer 2 draws with RGB 8'hFF (TRANSP_EN=1), layer 6 draws 8'h03 -> RGBOut=8'h03. Then clear layerEnable[6] -> RGBOut=backgroundRGB (8'h92), hitValid=0, hitLayer=0.
- Frame A has layers 1 and 4 overlapping on one pixel and layer 0 drawing alone elsewhere; then startOfFrame -> collisionValid pulses 2 clocks later with collisionOut=8'b0001_0010. Frame B has no overlaps -> the next pulse gives 8'h00.
- startOfFrame coincides with an overlap of layers 0 and 7 -> collisionOut reports the old frame only, and the next frame's report includes 8'h81.
- Assert resetN=0 for one clock mid-frame with the pipeline full -> all outputs 0 on the next edge, ranks return to identity, and the next collision report is 0.

Source files
------------

// File: rtl/vga_layers_pkg.sv
// Shared layer indices, colour key and rank type for the VGA layer merge path.
package vga_layers_pkg;
  localparam int LAYER_COLUMNS = 0;
  localparam int LAYER_BORDERS = 1;
  localparam int LAYER_BLAST   = 2;
  localparam int LAYER_PLAYER  = 3;
  localparam int LAYER_ENEMY   = 4;
  localparam int LAYER_BOMB    = 5;

  localparam int DEFAULT_NUM_LAYERS = 8;
  localparam logic [7:0] TRANSPARENT_COLOR = 8'hFF;
  localparam int DEFAULT_RANK_W = $clog2(DEFAULT_NUM_LAYERS);

  typedef logic [DEFAULT_RANK_W-1:0] rank_t;
endpackage

// File: rtl/rank_select.sv
// Combinational winner pick: lowest-rank drawing layer, lower index on ties.
// Zero latency; no flow control.
module rank_select
  import vga_layers_pkg::*;
#(
  parameter int NUM_LAYERS = DEFAULT_NUM_LAYERS,
  parameter int RANK_W     = DEFAULT_RANK_W
) (
  input  logic [NUM_LAYERS-1:0]             draw,
  input  logic [NUM_LAYERS-1:0][RANK_W-1:0] rank,
  output logic [RANK_W-1:0]                 winner,
  output logic                              found
);

  logic [RANK_W-1:0] best;

  // Strict less-than keeps the earliest index when ranks are equal.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    best   = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (draw[i] && (!found || rank[i] < best)) begin
        found  = 1'b1;
        best   = rank[i];
        winner = RANK_W'(i);
      end
    end
  end

endmodule

// File: rtl/layer_priority_mux.sv
// Ranked layer merge with per-frame collision vector.
// Latency 2 clk, one pixel per clock, no backpressure.
module layer_priority_mux
  import vga_layers_pkg::*;
#(
  parameter int                NUM_LAYERS  = DEFAULT_NUM_LAYERS,
  parameter int                RGB_W       = 8,
  parameter int                TRANSP_EN   = 1,
  parameter logic [RGB_W-1:0]  TRANSPARENT = RGB_W'(TRANSPARENT_COLOR),
  parameter int                RANK_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic [NUM_LAYERS-1:0]       layerDR,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]       layerEnable,
  input  logic [RGB_W-1:0]            backgroundRGB,
  input  logic                        startOfFrame,
  input  logic                        rankWrEn,
  input  logic [RANK_W-1:0]           rankWrIdx,
  input  logic [RANK_W-1:0]           rankWrVal,
  output logic [RGB_W-1:0]            RGBOut,
  output logic                        hitValid,
  output logic [RANK_W-1:0]           hitLayer,
  output logic [NUM_LAYERS-1:0]       collisionOut,
  output logic                        collisionValid
);

  logic [NUM_LAYERS-1:0]             drawNext;
  logic [NUM_LAYERS-1:0]             draw1;
  logic [NUM_LAYERS-1:0][RGB_W-1:0]  rgb1;
  logic [RGB_W-1:0]                  bg1;
  logic                              sof1;
  logic [NUM_LAYERS-1:0][RANK_W-1:0] rank;
  logic [NUM_LAYERS-1:0]             acc;
  logic [RANK_W-1:0]                 winner;
  logic                              found;
  logic                              multi;

  always_comb begin
    drawNext = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      drawNext[i] = layerDR[i] & layerEnable[i] &
                    !((TRANSP_EN != 0) && (layerRGB[i*RGB_W +: RGB_W] == TRANSPARENT));
    end
  end

  // Clearing the lowest set bit leaves something only when two or more layers draw.
  assign multi = |(draw1 & (draw1 - NUM_LAYERS'(1)));

  rank_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .RANK_W     (RANK_W)
  ) u_rank_select (
    .draw   (draw1),
    .rank   (rank),
    .winner (winner),
    .found  (found)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      draw1          <= '0;
      rgb1           <= '0;
      bg1            <= '0;
      sof1           <= 1'b0;
      RGBOut         <= '0;
      hitValid       <= 1'b0;
      hitLayer       <= '0;
      collisionOut   <= '0;
      collisionValid <= 1'b0;
      acc            <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) rank[i] <= RANK_W'(i);
    end else begin
      draw1 <= drawNext;
      rgb1  <= layerRGB;
      bg1   <= backgroundRGB;
      sof1  <= startOfFrame;

      RGBOut   <= found ? rgb1[winner] : bg1;
      hitValid <= found;
      hitLayer <= found ? winner : '0;

      // Indices beyond NUM_LAYERS never match, so such writes fall away.
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (rankWrEn && rankWrIdx == RANK_W'(i)) rank[i] <= rankWrVal;
      end

      if (sof1) begin
        collisionOut   <= acc;
        collisionValid <= 1'b1;
        acc            <= multi ? draw1 : '0;
      end else begin
        collisionValid <= 1'b0;
        if (multi) acc <= acc | draw1;
      end
    end
  end

endmodule
